// File: rtl/brush_pkg.sv
// brush_pkg: shared event type, FSM states and canvas defaults for the
// brush stamping path.
package brush_pkg;

  localparam int CANVAS_W_DEF = 320;
  localparam int CANVAS_H_DEF = 180;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 4;
  localparam int SW_W    = 3;

  // One brush event; the stroke width doubles as the stamp radius.
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic [SW_W-1:0]    sw;
  } brush_evt_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP
  } brush_state_t;

endpackage

// File: rtl/brush_clip.sv
// brush_clip: clips the (2r+1)x(2r+1) square centred on (x, y) to the
// canvas and flags stamps whose centre lies off the canvas as empty.
module brush_clip
  import brush_pkg::*;
#(
  parameter int CANVAS_W = CANVAS_W_DEF,
  parameter int CANVAS_H = CANVAS_H_DEF
) (
  input  logic [X_W-1:0]  i_x,
  input  logic [Y_W-1:0]  i_y,
  input  logic [SW_W-1:0] i_sw,
  output logic [X_W-1:0]  o_x0,
  output logic [X_W-1:0]  o_x1,
  output logic [Y_W-1:0]  o_y0,
  output logic [Y_W-1:0]  o_y1,
  output logic            o_empty
);

  localparam logic [X_W-1:0] X_LAST = X_W'(CANVAS_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(CANVAS_H - 1);

  // The low edge can go below zero, so it is formed signed one bit wider;
  // the high edge can only overflow upwards, so one extra unsigned bit is enough.
  logic signed [X_W:0] w_xLo;
  logic signed [Y_W:0] w_yLo;
  logic        [X_W:0] w_xHi;
  logic        [Y_W:0] w_yHi;

  // Form the raw square edges and clamp each against the canvas.
  always_comb begin
    w_xLo = $signed({1'b0, i_x}) - $signed({{(X_W + 1 - SW_W){1'b0}}, i_sw});
    w_yLo = $signed({1'b0, i_y}) - $signed({{(Y_W + 1 - SW_W){1'b0}}, i_sw});
    w_xHi = {1'b0, i_x} + {{(X_W + 1 - SW_W){1'b0}}, i_sw};
    w_yHi = {1'b0, i_y} + {{(Y_W + 1 - SW_W){1'b0}}, i_sw};

    o_x0 = w_xLo[X_W] ? '0 : w_xLo[X_W-1:0];
    o_y0 = w_yLo[Y_W] ? '0 : w_yLo[Y_W-1:0];
    o_x1 = (w_xHi > {1'b0, X_LAST}) ? X_LAST : w_xHi[X_W-1:0];
    o_y1 = (w_yHi > {1'b0, Y_LAST}) ? Y_LAST : w_yHi[Y_W-1:0];

    // A centre off the canvas discards the whole stamp, even if part of
    // the square would still overlap the canvas.
    o_empty = (i_x > X_LAST) || (i_y > Y_LAST);
  end

endmodule

// File: rtl/brush_stamper.sv
// brush_stamper: captures local and remote brush events, arbitrates between
// them round-robin and sweeps each stamp out as one pixel write per handshake.
module brush_stamper
  import brush_pkg::*;
#(
  parameter int CANVAS_W = CANVAS_W_DEF,
  parameter int CANVAS_H = CANVAS_H_DEF,
  parameter int ADDR_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [X_W-1:0]     loc_x_in,
  input  logic [Y_W-1:0]     loc_y_in,
  input  logic [COLOR_W-1:0] loc_color_in,
  input  logic [SW_W-1:0]    loc_sw_in,
  input  logic               loc_valid_in,
  input  logic [X_W-1:0]     rem_x_in,
  input  logic [Y_W-1:0]     rem_y_in,
  input  logic [COLOR_W-1:0] rem_color_in,
  input  logic [SW_W-1:0]    rem_sw_in,
  input  logic               rem_valid_in,
  output logic [ADDR_W-1:0]  wr_addr_out,
  output logic [COLOR_W-1:0] wr_color_out,
  output logic               wr_valid_out,
  input  logic               wr_ready_in,
  output logic               busy_out
);

  brush_state_t r_state;
  brush_state_t w_nextState;

  brush_evt_t w_locEvt;
  brush_evt_t w_remEvt;
  brush_evt_t r_locSlot;
  brush_evt_t r_remSlot;
  brush_evt_t r_locLast;
  brush_evt_t r_remLast;
  brush_evt_t r_evt;

  logic r_locPend;
  logic r_remPend;
  logic r_locLastVld;
  logic r_remLastVld;
  logic r_rrLocal;

  logic w_locDup;
  logic w_remDup;
  logic w_grantLoc;
  logic w_grantRem;

  logic [X_W-1:0] w_clipX0;
  logic [X_W-1:0] w_clipX1;
  logic [Y_W-1:0] w_clipY0;
  logic [Y_W-1:0] w_clipY1;
  logic           w_clipEmpty;

  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x1;
  logic [Y_W-1:0] r_y1;
  logic [X_W-1:0] r_cx;
  logic [Y_W-1:0] r_cy;

  logic              w_fire;
  logic              w_rowDone;
  logic              w_sweepDone;
  logic [ADDR_W-1:0] w_cxExt;
  logic [ADDR_W-1:0] w_cyExt;
  logic [ADDR_W-1:0] w_addr;

  assign w_locEvt = '{x: loc_x_in, y: loc_y_in, color: loc_color_in, sw: loc_sw_in};
  assign w_remEvt = '{x: rem_x_in, y: rem_y_in, color: rem_color_in, sw: rem_sw_in};

  // A repeat of the last stamped event from the same source adds nothing to
  // the canvas, so it is dropped before it reaches the pending slot.
  assign w_locDup = r_locLastVld && (w_locEvt == r_locLast);
  assign w_remDup = r_remLastVld && (w_remEvt == r_remLast);

  // Round-robin: r_rrLocal names the source preferred when both are pending.
  assign w_grantLoc = (r_state == IDLE) && r_locPend && (!r_remPend || r_rrLocal);
  assign w_grantRem = (r_state == IDLE) && r_remPend && !w_grantLoc;

  assign w_fire      = wr_valid_out && wr_ready_in;
  assign w_rowDone   = (r_cx == r_x1);
  assign w_sweepDone = w_rowDone && (r_cy == r_y1);

  brush_clip #(
    .CANVAS_W (CANVAS_W),
    .CANVAS_H (CANVAS_H)
  ) u_clip (
    .i_x     (r_evt.x),
    .i_y     (r_evt.y),
    .i_sw    (r_evt.sw),
    .o_x0    (w_clipX0),
    .o_x1    (w_clipX1),
    .o_y0    (w_clipY0),
    .o_y1    (w_clipY1),
    .o_empty (w_clipEmpty)
  );

  assign w_cxExt = ADDR_W'(r_cx);
  assign w_cyExt = ADDR_W'(r_cy);

  // The default 320-pixel row stride is 256 + 64, so it folds into two shifts.
  generate
    if (CANVAS_W == 320) begin : g_addrShift
      assign w_addr = (w_cyExt << 8) + (w_cyExt << 6) + w_cxExt;
    end else begin : g_addrMul
      assign w_addr = (w_cyExt * ADDR_W'(CANVAS_W)) + w_cxExt;
    end
  endgenerate

  // Capture strobes into the per-source slots and move the granted event into the stamp register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_locSlot    <= '0;
      r_remSlot    <= '0;
      r_locLast    <= '0;
      r_remLast    <= '0;
      r_evt        <= '0;
      r_locPend    <= 1'b0;
      r_remPend    <= 1'b0;
      r_locLastVld <= 1'b0;
      r_remLastVld <= 1'b0;
      r_rrLocal    <= 1'b1;
    end else begin
      if (w_grantLoc) begin
        r_evt        <= r_locSlot;
        r_locPend    <= 1'b0;
        r_locLast    <= r_locSlot;
        r_locLastVld <= 1'b1;
        r_rrLocal    <= 1'b0;
      end else if (w_grantRem) begin
        r_evt        <= r_remSlot;
        r_remPend    <= 1'b0;
        r_remLast    <= r_remSlot;
        r_remLastVld <= 1'b1;
        r_rrLocal    <= 1'b1;
      end
      // Placed after the grant so a same-cycle strobe re-arms the slot.
      if (loc_valid_in && !w_locDup) begin
        r_locSlot <= w_locEvt;
        r_locPend <= 1'b1;
      end
      if (rem_valid_in && !w_remDup) begin
        r_remSlot <= w_remEvt;
        r_remPend <= 1'b1;
      end
    end
  end

  // Latch clipped bounds in LOAD, then walk the rectangle x-fastest on each accepted write.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_state == LOAD) begin
      r_x0 <= w_clipX0;
      r_x1 <= w_clipX1;
      r_y1 <= w_clipY1;
      r_cx <= w_clipX0;
      r_cy <= w_clipY0;
    end else if (r_state == SWEEP && w_fire && !w_sweepDone) begin
      if (w_rowDone) begin
        r_cx <= r_x0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: grant, bound load, then sweep until the last corner is accepted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grantLoc || w_grantRem) w_nextState = LOAD;
      LOAD:    w_nextState = w_clipEmpty ? IDLE : SWEEP;
      SWEEP:   if (w_fire && w_sweepDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decode from the state alone, so an async reset clears them at once.
  always_comb begin
    wr_valid_out = 1'b0;
    wr_addr_out  = '0;
    wr_color_out = '0;
    busy_out     = 1'b0;
    case (r_state)
      LOAD: begin
        busy_out = 1'b1;
      end
      SWEEP: begin
        busy_out     = 1'b1;
        wr_valid_out = 1'b1;
        wr_addr_out  = w_addr;
        wr_color_out = r_evt.color;
      end
      default: begin
      end
    endcase
  end

endmodule
